// File: rtl/regfile_wb_buffer_pkg.sv
// Shared types for the register-file write-back buffer.
// Holds register geometry, the queued write-request layout and the FSM states.
package regfile_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    typedef enum logic {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_wb_buffer_if.sv
// Pipeline-facing request bus, register-file write port, read snoop and status for the write-back buffer.
// master = pipeline/regfile side, slave = buffer side.
interface regfile_wb_buffer_if
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              ReqValid;
    logic              ReqReady;
    logic [ADDR_W-1:0] ReqRegister;
    logic [DATA_W-1:0] ReqData;
    logic              DrainEn;
    logic [ADDR_W-1:0] WriteRegister;
    logic [DATA_W-1:0] WriteData;
    logic              RegWrite;
    logic [ADDR_W-1:0] ReadRegister1;
    logic [ADDR_W-1:0] ReadRegister2;
    logic              FwdHit1;
    logic [DATA_W-1:0] FwdData1;
    logic              FwdHit2;
    logic [DATA_W-1:0] FwdData2;
    logic [CNT_W-1:0]  Count;
    logic              Busy;

    modport master (
        output ReqValid, ReqRegister, ReqData, DrainEn, ReadRegister1, ReadRegister2,
        input  ReqReady, WriteRegister, WriteData, RegWrite,
        input  FwdHit1, FwdData1, FwdHit2, FwdData2, Count, Busy
    );

    modport slave (
        input  ReqValid, ReqRegister, ReqData, DrainEn, ReadRegister1, ReadRegister2,
        output ReqReady, WriteRegister, WriteData, RegWrite,
        output FwdHit1, FwdData1, FwdHit2, FwdData2, Count, Busy
    );

endinterface

// File: rtl/regfile_wb_buffer_wb_fifo.sv
// Circular write-request queue; push lands in storage at the clock edge, head is visible combinationally.
// Caller guarantees no push when full and no pop when empty; all entries are exported for forwarding.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                push_i,
    input  wr_req_t             push_dat_i,
    input  logic                pop_i,
    output wr_req_t             head_o,
    output logic [CNT_W-1:0]    count_o,
    output logic [PTR_W-1:0]    rd_ptr_o,
    output logic [DEPTH-1:0]    vld_o,
    output wr_req_t [DEPTH-1:0] mem_o
);

    wr_req_t [DEPTH-1:0] mem_q;
    logic [DEPTH-1:0]    vld_q, vld_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;

    always_comb begin
        vld_d    = vld_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (pop_i) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + PTR_W'(1);
        end
        if (push_i) begin
            vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload needs no reset: every read of it is qualified by a valid bit.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    assign head_o   = mem_q[rd_ptr_q];
    assign count_o  = count_q;
    assign rd_ptr_o = rd_ptr_q;
    assign vld_o    = vld_q;
    assign mem_o    = mem_q;

endmodule

// File: rtl/regfile_wb_buffer.sv
// Write-back buffer ahead of the 32x32 regfile; commit appears on RegWrite two edges after an accept into an empty queue.
// ReqReady drops when full or sweeping; DrainEn=0 freezes the drain; REGFILE_WB_CLEAR_EN adds a post-reset zeroing sweep.
module regfile_wb_buffer
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               Clk,
    input  logic               Reset_n,
    regfile_wb_buffer_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

`ifdef REGFILE_WB_CLEAR_EN
    localparam state_t RST_STATE = CLEAR;
    logic [ADDR_W-1:0] sweep_q, sweep_d;
`else
    localparam state_t RST_STATE = RUN;
`endif

    wr_req_t             head;
    logic [CNT_W-1:0]    count;
    logic [PTR_W-1:0]    rd_ptr;
    logic [DEPTH-1:0]    vld;
    wr_req_t [DEPTH-1:0] mem;

    state_t            state_q, state_d;
    logic              regwrite_q, regwrite_d;
    logic [ADDR_W-1:0] wreg_q, wreg_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic req_rdy, push, pop;

    assign req_rdy = (state_q == RUN) && (count < CNT_W'(DEPTH));
    // Writes to r0 complete the handshake but are never stored.
    assign push    = bus.ReqValid && req_rdy && (bus.ReqRegister != ZERO_REG);
    assign pop     = (state_q == RUN) && bus.DrainEn && (count != '0);

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i      (Clk),
        .rst_ni     (Reset_n),
        .push_i     (push),
        .push_dat_i ('{addr: bus.ReqRegister, data: bus.ReqData}),
        .pop_i      (pop),
        .head_o     (head),
        .count_o    (count),
        .rd_ptr_o   (rd_ptr),
        .vld_o      (vld),
        .mem_o      (mem)
    );

    always_comb begin
        state_d    = state_q;
        regwrite_d = pop;
        wreg_d     = wreg_q;
        wdata_d    = wdata_q;
        if (pop) begin
            wreg_d  = head.addr;
            wdata_d = head.data;
        end
`ifdef REGFILE_WB_CLEAR_EN
        sweep_d = sweep_q;
        if (state_q == CLEAR) begin
            regwrite_d = 1'b1;
            wreg_d     = sweep_q;
            wdata_d    = '0;
            sweep_d    = sweep_q + ADDR_W'(1);
            if (sweep_q == ADDR_W'(NUM_REGS - 1)) begin
                state_d = RUN;
            end
        end
`endif
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= RST_STATE;
            regwrite_q <= 1'b0;
            wreg_q     <= '0;
            wdata_q    <= '0;
`ifdef REGFILE_WB_CLEAR_EN
            sweep_q    <= ADDR_W'(1);
`endif
        end else begin
            state_q    <= state_d;
            regwrite_q <= regwrite_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
`ifdef REGFILE_WB_CLEAR_EN
            sweep_q    <= sweep_d;
`endif
        end
    end

    // Queue slot holding the k-th oldest entry.
    logic [PTR_W-1:0] age_idx [DEPTH];
    for (genvar k = 0; k < DEPTH; k++) begin : g_age
        assign age_idx[k] = rd_ptr + PTR_W'(k);
    end

    logic [1:0][ADDR_W-1:0] rd_addr;
    logic [1:0]             fwd_hit;
    logic [1:0][DATA_W-1:0] fwd_dat;

    assign rd_addr[0] = bus.ReadRegister1;
    assign rd_addr[1] = bus.ReadRegister2;

    // Lowest priority first (output stage, then oldest to newest) so later matches override.
    always_comb begin
        fwd_hit = '0;
        fwd_dat = '0;
        for (int p = 0; p < 2; p++) begin
            if (regwrite_q && (wreg_q == rd_addr[p])) begin
                fwd_hit[p] = 1'b1;
                fwd_dat[p] = wdata_q;
            end
            for (int k = 0; k < DEPTH; k++) begin
                if (vld[age_idx[k]] && (mem[age_idx[k]].addr == rd_addr[p])) begin
                    fwd_hit[p] = 1'b1;
                    fwd_dat[p] = mem[age_idx[k]].data;
                end
            end
            if ((state_q != RUN) || (rd_addr[p] == ZERO_REG)) begin
                fwd_hit[p] = 1'b0;
                fwd_dat[p] = '0;
            end
        end
    end

    assign bus.ReqReady      = req_rdy;
    assign bus.WriteRegister = wreg_q;
    assign bus.WriteData     = wdata_q;
    assign bus.RegWrite      = regwrite_q;
    assign bus.FwdHit1       = fwd_hit[0];
    assign bus.FwdData1      = fwd_dat[0];
    assign bus.FwdHit2       = fwd_hit[1];
    assign bus.FwdData2      = fwd_dat[1];
    assign bus.Count         = count;
`ifdef REGFILE_WB_CLEAR_EN
    assign bus.Busy          = (state_q == CLEAR);
`else
    assign bus.Busy          = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_buffer.sv
// Directed bench for regfile_wb_buffer: commits are checked against a queue of expected writes.
// Also models the downstream regfile to confirm what actually lands there.
module tb_regfile_wb_buffer;
    import regfile_pkg::*;

    localparam int DEPTH = 4;

    logic Clk     = 1'b0;
    logic Reset_n = 1'b0;

    regfile_wb_buffer_if #(.DEPTH(DEPTH)) bus ();

    regfile_wb_buffer #(.DEPTH(DEPTH)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    wr_req_t exp_q [$];
    logic [DATA_W-1:0] rf [NUM_REGS];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic push(input int a, input int d);
        int n = 0;
        bus.ReqValid    = 1'b1;
        bus.ReqRegister = ADDR_W'(a);
        bus.ReqData     = DATA_W'(d);
        while (bus.ReqReady !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("push_ready_timeout", 64'(n < 50), 64'd1);
        if (a != 0) exp_q.push_back(wr_req_t'{addr: ADDR_W'(a), data: DATA_W'(d)});
        tick();
        bus.ReqValid = 1'b0;
    endtask

    // Expect the zeroing sweep (only exists in the sweep build) and wait it out.
    task automatic expect_sweep();
`ifdef REGFILE_WB_CLEAR_EN
        int n = 0;
        int bad_rdy = 0;
        for (int r = 1; r < NUM_REGS; r++) exp_q.push_back(wr_req_t'{addr: ADDR_W'(r), data: '0});
        while (bus.Busy === 1'b1 && n < 40) begin
            if (bus.ReqReady !== 1'b0 || bus.FwdHit1 !== 1'b0) bad_rdy++;
            n++;
            tick();
        end
        chk("clear_busy_cycles", 64'(n), 64'd31);
        chk("clear_rdy_low", 64'(bad_rdy), 64'd0);
        tick();
`endif
    endtask

    always @(posedge Clk) begin
        if (Reset_n && bus.RegWrite === 1'b1) rf[bus.WriteRegister] <= bus.WriteData;
    end

    wr_req_t mon_e;
    always @(negedge Clk) begin
        if (Reset_n && bus.RegWrite !== 1'b0) begin
            chk("commit_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("commit_addr", 64'(bus.WriteRegister), 64'(mon_e.addr));
                chk("commit_data", 64'(bus.WriteData), 64'(mon_e.data));
            end
        end
    end

    initial begin
        int n_wr;
        bus.ReqValid      = 1'b0;
        bus.ReqRegister   = '0;
        bus.ReqData       = '0;
        bus.DrainEn       = 1'b0;
        bus.ReadRegister1 = '0;
        bus.ReadRegister2 = '0;
        #2;
        chk("rst_regwrite", 64'(bus.RegWrite), 64'd0);
        chk("rst_wreg", 64'(bus.WriteRegister), 64'd0);
        chk("rst_wdata", 64'(bus.WriteData), 64'd0);
        chk("rst_count", 64'(bus.Count), 64'd0);
`ifdef REGFILE_WB_CLEAR_EN
        chk("rst_busy", 64'(bus.Busy), 64'd1);
        chk("rst_ready", 64'(bus.ReqReady), 64'd0);
        #1 Reset_n = 1'b1;
        expect_sweep();
        chk("clear_rf1", 64'(rf[1]), 64'd0);
        chk("clear_rf31", 64'(rf[31]), 64'd0);
        bus.DrainEn = 1'b1;
        push(7, 3);
        tick(2);
        chk("clear_then_commit", 64'(rf[7]), 64'd3);
`else
        chk("rst_busy", 64'(bus.Busy), 64'd0);
        chk("rst_ready", 64'(bus.ReqReady), 64'd1);
        #1 Reset_n = 1'b1;
        tick();
`endif

        // Basic commit and its latency.
        bus.DrainEn = 1'b1;
        push(2, 42);
        chk("basic_no_early", 64'(bus.RegWrite), 64'd0);
        chk("basic_count1", 64'(bus.Count), 64'd1);
        tick();
        chk("basic_regwrite", 64'(bus.RegWrite), 64'd1);
        chk("basic_wreg", 64'(bus.WriteRegister), 64'd2);
        chk("basic_wdata", 64'(bus.WriteData), 64'd42);
        tick();
        chk("basic_one_cycle", 64'(bus.RegWrite), 64'd0);
        chk("basic_rf", 64'(rf[2]), 64'd42);

        // Fill, hold a fifth request, then drain in order.
        bus.DrainEn = 1'b0;
        for (int i = 1; i <= 4; i++) push(i, i);
        chk("full_count", 64'(bus.Count), 64'd4);
        chk("full_ready", 64'(bus.ReqReady), 64'd0);
        bus.ReqValid    = 1'b1;
        bus.ReqRegister = ADDR_W'(5);
        bus.ReqData     = DATA_W'(5);
        exp_q.push_back(wr_req_t'{addr: ADDR_W'(5), data: DATA_W'(5)});
        tick();
        chk("full_held_count", 64'(bus.Count), 64'd4);
        chk("full_held_ready", 64'(bus.ReqReady), 64'd0);
        bus.DrainEn = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("drain_vld", 64'(bus.RegWrite), 64'd1);
            chk("drain_order", 64'(bus.WriteRegister), 64'(i));
            if (i == 1) chk("drain_ready_back", 64'(bus.ReqReady), 64'd1);
            if (i == 2) begin
                chk("push_pop_count", 64'(bus.Count), 64'd3);
                bus.ReqValid = 1'b0;
            end
        end
        tick();
        chk("held_commit", 64'(bus.WriteRegister), 64'd5);
        chk("held_count0", 64'(bus.Count), 64'd0);
        tick();

        // Forwarding priority: newest queue entry over older, queue over output stage.
        bus.DrainEn = 1'b0;
        push(5, 7);
        push(5, 9);
        bus.ReadRegister1 = ADDR_W'(5);
        bus.ReadRegister2 = ADDR_W'(6);
        #1;
        chk("fwd1_hit", 64'(bus.FwdHit1), 64'd1);
        chk("fwd1_newest", 64'(bus.FwdData1), 64'd9);
        chk("fwd2_miss", 64'(bus.FwdHit2), 64'd0);
        chk("fwd2_zero", 64'(bus.FwdData2), 64'd0);
        bus.DrainEn = 1'b1;
        tick();
        chk("fwd_queue_over_out", 64'(bus.FwdData1), 64'd9);
        tick();
        chk("fwd_out_hit", 64'(bus.FwdHit1), 64'd1);
        chk("fwd_out_data", 64'(bus.FwdData1), 64'd9);
        tick();
        chk("fwd_done_hit1", 64'(bus.FwdHit1), 64'd0);
        chk("fwd_done_data1", 64'(bus.FwdData1), 64'd0);
        chk("fwd_done_hit2", 64'(bus.FwdHit2), 64'd0);

        // Register 0 writes are swallowed.
        bus.ReadRegister1 = '0;
        push(0, 8);
        chk("zero_count", 64'(bus.Count), 64'd0);
        chk("zero_nohit", 64'(bus.FwdHit1), 64'd0);
        tick();
        chk("zero_no_regwrite", 64'(bus.RegWrite), 64'd0);

        // Reset with three pending writes: all must vanish.
        bus.DrainEn = 1'b0;
        push(3, 11);
        push(4, 12);
        push(6, 13);
        chk("pre_reset_count", 64'(bus.Count), 64'd3);
        bus.ReadRegister1 = ADDR_W'(4);
        bus.ReadRegister2 = ADDR_W'(6);
        #1;
        chk("pre_reset_hit", 64'(bus.FwdHit1), 64'd1);
        #1 Reset_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_regwrite", 64'(bus.RegWrite), 64'd0);
        chk("mid_rst_count", 64'(bus.Count), 64'd0);
        chk("mid_rst_hit1", 64'(bus.FwdHit1), 64'd0);
        chk("mid_rst_hit2", 64'(bus.FwdHit2), 64'd0);
        #4 Reset_n = 1'b1;
        tick();
        expect_sweep();
        bus.DrainEn = 1'b1;
        n_wr = 0;
        repeat (8) begin
            tick();
            if (bus.RegWrite !== 1'b0) n_wr++;
        end
        chk("reset_no_commit", 64'(n_wr), 64'd0);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
